// File: rtl/tlb_access_arbiter_if.sv
// rtl/tlb_access_arbiter_if.sv - request, response and TLB-drive bundle of the TLB access arbiter
//
// Purpose: groups every handshake/bus signal of tlb_access_arbiter.
//   slave  : the arbiter side (consumes requests, drives the shared TLB port and responses)
//   master : the environment side (requesters, PTW, SFENCE source and the TLB itself)
// Signals:
//   ilu_* / dlu_*   instruction / data lookup request (valid, ready, vaddr, asid)
//   upd_*           PTW refill request into the one-entry refill buffer
//   flush_*         SFENCE request, acceptance and completion pulse
//   tlb_*           drive to / result from the shared cva6_tlb_sv32 instance
//   resp_*          registered lookup response and its owner id
interface tlb_access_arbiter_if #(
   parameter int ASID_WIDTH = 9,
   parameter int VLEN       = 32
);
   logic                  ilu_valid_i;
   logic                  ilu_ready_o;
   logic [VLEN-1:0]       ilu_vaddr_i;
   logic [ASID_WIDTH-1:0] ilu_asid_i;

   logic                  dlu_valid_i;
   logic                  dlu_ready_o;
   logic [VLEN-1:0]       dlu_vaddr_i;
   logic [ASID_WIDTH-1:0] dlu_asid_i;

   logic                  upd_valid_i;
   logic                  upd_ready_o;
   logic [19:0]           upd_vpn_i;
   logic [ASID_WIDTH-1:0] upd_asid_i;
   logic                  upd_is_4M_i;
   logic [31:0]           upd_content_i;

   logic                  flush_valid_i;
   logic                  flush_ready_o;
   logic [VLEN-1:0]       flush_vaddr_i;
   logic [ASID_WIDTH-1:0] flush_asid_i;
   logic                  flush_done_o;

   logic                  tlb_flush_o;
   logic [VLEN-1:0]       tlb_vaddr_flush_o;
   logic [ASID_WIDTH-1:0] tlb_asid_flush_o;
   logic [62:0]           tlb_update_o;
   logic                  tlb_lu_access_o;
   logic [VLEN-1:0]       tlb_lu_vaddr_o;
   logic [ASID_WIDTH-1:0] tlb_lu_asid_o;
   logic                  tlb_lu_hit_i;
   logic [31:0]           tlb_lu_content_i;
   logic                  tlb_lu_is_4M_i;

   logic                  resp_valid_o;
   logic                  resp_id_o;
   logic                  resp_hit_o;
   logic [31:0]           resp_content_o;
   logic                  resp_is_4M_o;

   modport slave (
      input  ilu_valid_i, ilu_vaddr_i, ilu_asid_i,
      output ilu_ready_o,
      input  dlu_valid_i, dlu_vaddr_i, dlu_asid_i,
      output dlu_ready_o,
      input  upd_valid_i, upd_vpn_i, upd_asid_i, upd_is_4M_i, upd_content_i,
      output upd_ready_o,
      input  flush_valid_i, flush_vaddr_i, flush_asid_i,
      output flush_ready_o, flush_done_o,
      output tlb_flush_o, tlb_vaddr_flush_o, tlb_asid_flush_o, tlb_update_o,
      output tlb_lu_access_o, tlb_lu_vaddr_o, tlb_lu_asid_o,
      input  tlb_lu_hit_i, tlb_lu_content_i, tlb_lu_is_4M_i,
      output resp_valid_o, resp_id_o, resp_hit_o, resp_content_o, resp_is_4M_o
   );

   modport master (
      output ilu_valid_i, ilu_vaddr_i, ilu_asid_i,
      input  ilu_ready_o,
      output dlu_valid_i, dlu_vaddr_i, dlu_asid_i,
      input  dlu_ready_o,
      output upd_valid_i, upd_vpn_i, upd_asid_i, upd_is_4M_i, upd_content_i,
      input  upd_ready_o,
      output flush_valid_i, flush_vaddr_i, flush_asid_i,
      input  flush_ready_o, flush_done_o,
      input  tlb_flush_o, tlb_vaddr_flush_o, tlb_asid_flush_o, tlb_update_o,
      input  tlb_lu_access_o, tlb_lu_vaddr_o, tlb_lu_asid_o,
      output tlb_lu_hit_i, tlb_lu_content_i, tlb_lu_is_4M_i,
      input  resp_valid_o, resp_id_o, resp_hit_o, resp_content_o, resp_is_4M_o
   );
endinterface

// File: rtl/tlb_access_arbiter.sv
// rtl/tlb_access_arbiter.sv - sequencer/arbiter sharing one TLB port between lookups, refills and flushes
//
// Purpose: lets instruction lookups, data lookups, PTW refills and SFENCE flushes share a single
//   cva6_tlb_sv32 port. Flushes take priority and run as IDLE -> FLUSH -> DRAIN so that no lookup
//   is ever granted against a partially flushed TLB. Refills wait in a one-entry buffer; lookups
//   are round-robin arbitrated and their results are registered and tagged with the owner.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    tlb_access_arbiter_if.slave (requests, TLB drive, responses)
module tlb_access_arbiter #(
   parameter int ASID_WIDTH = 9,
   parameter int VLEN       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   tlb_access_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;

   logic                  buf_full;
   logic [19:0]           buf_vpn;
   logic [ASID_WIDTH-1:0] buf_asid;
   logic                  buf_is_4m;
   logic [31:0]           buf_content;

   // 0 = instruction side wins a tie, 1 = data side wins a tie
   logic                  rr_ptr;

   logic [VLEN-1:0]       fl_vaddr;
   logic [ASID_WIDTH-1:0] fl_asid;

   logic                  flush_done_q;
   logic                  resp_valid_q;
   logic                  resp_id_q;
   logic                  resp_hit_q;
   logic [31:0]           resp_content_q;
   logic                  resp_is_4m_q;

   logic                  idle_op;
   logic                  take_flush;
   logic                  issue_upd;
   logic                  lu_slot;
   logic                  grant_i;
   logic                  grant_d;
   logic                  upd_accept;
   logic                  flush_issue;
   logic [ASID_WIDTH+8:0] buf_asid_ext;

   // Every TLB operation and every ready is suppressed while rst_i is high, so a reset
   // landing mid-flush or mid-refill issues nothing in that cycle.
   always_comb begin
      idle_op      = (state == IDLE) && !rst_i;
      take_flush   = idle_op && bus.flush_valid_i;
      issue_upd    = idle_op && !bus.flush_valid_i && buf_full;
      lu_slot      = idle_op && !bus.flush_valid_i && !buf_full;
      grant_i      = lu_slot && bus.ilu_valid_i && (!bus.dlu_valid_i || !rr_ptr);
      grant_d      = lu_slot && bus.dlu_valid_i && (!bus.ilu_valid_i || rr_ptr);
      upd_accept   = bus.upd_valid_i && !buf_full && !rst_i;
      flush_issue  = (state == FLUSH) && !rst_i;
      // The TLB update word always carries a 9-bit ASID: zero-extend, then keep the low 9 bits.
      buf_asid_ext = {9'd0, buf_asid};
   end

   assign bus.ilu_ready_o       = grant_i;
   assign bus.dlu_ready_o       = grant_d;
   assign bus.upd_ready_o       = !buf_full && !rst_i;
   assign bus.flush_ready_o     = take_flush;
   assign bus.flush_done_o      = flush_done_q;

   assign bus.tlb_flush_o       = flush_issue;
   assign bus.tlb_vaddr_flush_o = flush_issue ? fl_vaddr : '0;
   assign bus.tlb_asid_flush_o  = flush_issue ? fl_asid : '0;
   assign bus.tlb_update_o      = issue_upd ?
                                  {1'b1, buf_is_4m, buf_vpn, buf_asid_ext[8:0], buf_content} : '0;
   assign bus.tlb_lu_access_o   = grant_i || grant_d;
   assign bus.tlb_lu_vaddr_o    = grant_i ? bus.ilu_vaddr_i : (grant_d ? bus.dlu_vaddr_i : '0);
   assign bus.tlb_lu_asid_o     = grant_i ? bus.ilu_asid_i : (grant_d ? bus.dlu_asid_i : '0);

   assign bus.resp_valid_o      = resp_valid_q;
   assign bus.resp_id_o         = resp_id_q;
   assign bus.resp_hit_o        = resp_hit_q;
   assign bus.resp_content_o    = resp_content_q;
   assign bus.resp_is_4M_o      = resp_is_4m_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         buf_full       <= 1'b0;
         buf_vpn        <= '0;
         buf_asid       <= '0;
         buf_is_4m      <= 1'b0;
         buf_content    <= '0;
         rr_ptr         <= 1'b0;
         fl_vaddr       <= '0;
         fl_asid        <= '0;
         flush_done_q   <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_id_q      <= 1'b0;
         resp_hit_q     <= 1'b0;
         resp_content_q <= '0;
         resp_is_4m_q   <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         resp_valid_q <= 1'b0;

         case (state)
            IDLE: begin
               if (take_flush) begin
                  fl_vaddr <= bus.flush_vaddr_i;
                  fl_asid  <= bus.flush_asid_i;
                  state    <= FLUSH;
               end
            end
            FLUSH: begin
               // done is registered so it is high exactly during the DRAIN cycle
               flush_done_q <= 1'b1;
               state        <= DRAIN;
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // A buffered refill only leaves through an IDLE issue slot; new refills are only
         // taken while empty, so the two branches never coincide.
         if (issue_upd) begin
            buf_full <= 1'b0;
         end else if (upd_accept) begin
            buf_full    <= 1'b1;
            buf_vpn     <= bus.upd_vpn_i;
            buf_asid    <= bus.upd_asid_i;
            buf_is_4m   <= bus.upd_is_4M_i;
            buf_content <= bus.upd_content_i;
         end

         if (grant_i || grant_d) begin
            rr_ptr         <= grant_i;
            resp_valid_q   <= 1'b1;
            resp_id_q      <= grant_d;
            resp_hit_q     <= bus.tlb_lu_hit_i;
            resp_content_q <= bus.tlb_lu_content_i;
            resp_is_4m_q   <= bus.tlb_lu_is_4M_i;
         end
      end
   end

endmodule

// File: tb/tb_tlb_access_arbiter.sv
// tb/tb_tlb_access_arbiter.sv - self-checking bench for tlb_access_arbiter with a behavioural TLB
module tb_tlb_access_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   bit   checking;

   tlb_access_arbiter_if #(.ASID_WIDTH(9), .VLEN(32)) bus ();

   tlb_access_arbiter #(.ASID_WIDTH(9), .VLEN(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural TLB: 8 fully associative entries, flush clears all
   logic        e_v   [8];
   logic [28:0] e_key [8];
   logic [31:0] e_c   [8];
   logic        e_4m  [8];
   logic [2:0]  rep;
   int          slot;

   function automatic logic [33:0] tlb_lookup(input logic [31:0] va, input logic [8:0] asid);
      for (int i = 0; i < 8; i++) begin
         if (e_v[i] && e_key[i] == {asid, va[31:12]}) return {1'b1, e_4m[i], e_c[i]};
      end
      return '0;
   endfunction

   logic [33:0] lk;
   always_comb lk = tlb_lookup(bus.tlb_lu_vaddr_o, bus.tlb_lu_asid_o);
   assign bus.tlb_lu_hit_i     = bus.tlb_lu_access_o & lk[33];
   assign bus.tlb_lu_is_4M_i   = bus.tlb_lu_access_o & lk[32];
   assign bus.tlb_lu_content_i = bus.tlb_lu_access_o ? lk[31:0] : 32'd0;

   always @(posedge clk) begin
      if (bus.tlb_flush_o) begin
         for (int i = 0; i < 8; i++) e_v[i] <= 1'b0;
      end else if (bus.tlb_update_o[62]) begin
         slot = int'(rep);
         for (int i = 0; i < 8; i++)
            if (e_v[i] && e_key[i] == {bus.tlb_update_o[40:32], bus.tlb_update_o[60:41]}) slot = i;
         e_v[slot]   <= 1'b1;
         e_key[slot] <= {bus.tlb_update_o[40:32], bus.tlb_update_o[60:41]};
         e_c[slot]   <= bus.tlb_update_o[31:0];
         e_4m[slot]  <= bus.tlb_update_o[61];
         if (slot == int'(rep)) rep <= rep + 3'd1;
      end
   end

   // ---------------- comparison helper
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: flush countdown, refill queue, tie preference
   typedef struct packed {
      logic [19:0] vpn;
      logic [8:0]  asid;
      logic        is4m;
      logic [31:0] c;
   } refill_t;

   refill_t     rq[$];
   int          flush_left;   // 2 = flush being issued, 1 = draining, 0 = free
   logic [31:0] m_fv;
   logic [8:0]  m_fa;
   bit          prefer_d;
   logic        m_rv, m_rid, m_rhit, m_r4m;
   logic [31:0] m_rc;
   bit          live, idle, fl_take, upd_go, lu_free;
   int          win;
   logic [31:0] e_va;
   logic [8:0]  e_as;
   logic [62:0] e_upd;
   logic [33:0] e_lk;

   always @(negedge clk) begin
      if (checking) begin
         live    = !rst;
         idle    = live && flush_left == 0;
         fl_take = idle && bus.flush_valid_i;
         upd_go  = idle && !bus.flush_valid_i && rq.size() != 0;
         lu_free = idle && !bus.flush_valid_i && rq.size() == 0;
         win = -1;
         if (lu_free) begin
            if (bus.ilu_valid_i && bus.dlu_valid_i) win = prefer_d ? 1 : 0;
            else if (bus.ilu_valid_i) win = 0;
            else if (bus.dlu_valid_i) win = 1;
         end
         e_va  = (win == 0) ? bus.ilu_vaddr_i : (win == 1) ? bus.dlu_vaddr_i : 32'd0;
         e_as  = (win == 0) ? bus.ilu_asid_i  : (win == 1) ? bus.dlu_asid_i  : 9'd0;
         e_upd = upd_go ? {1'b1, rq[0].is4m, rq[0].vpn, rq[0].asid, rq[0].c} : 63'd0;

         chk("ilu_ready", 64'(bus.ilu_ready_o), 64'(win == 0));
         chk("dlu_ready", 64'(bus.dlu_ready_o), 64'(win == 1));
         chk("upd_ready", 64'(bus.upd_ready_o), 64'(live && rq.size() == 0));
         chk("flush_ready", 64'(bus.flush_ready_o), 64'(fl_take));
         chk("flush_done", 64'(bus.flush_done_o), 64'(flush_left == 1));
         chk("tlb_flush", 64'(bus.tlb_flush_o), 64'(live && flush_left == 2));
         chk("tlb_vaddr_flush", 64'(bus.tlb_vaddr_flush_o), (live && flush_left == 2) ? 64'(m_fv) : 64'd0);
         chk("tlb_asid_flush", 64'(bus.tlb_asid_flush_o), (live && flush_left == 2) ? 64'(m_fa) : 64'd0);
         chk("tlb_update", 64'(bus.tlb_update_o), 64'(e_upd));
         chk("tlb_lu_access", 64'(bus.tlb_lu_access_o), 64'(win >= 0));
         chk("tlb_lu_vaddr", 64'(bus.tlb_lu_vaddr_o), 64'(e_va));
         chk("tlb_lu_asid", 64'(bus.tlb_lu_asid_o), 64'(e_as));
         chk("resp_valid", 64'(bus.resp_valid_o), 64'(m_rv));
         chk("resp_id", 64'(bus.resp_id_o), 64'(m_rid));
         chk("resp_hit", 64'(bus.resp_hit_o), 64'(m_rhit));
         chk("resp_content", 64'(bus.resp_content_o), 64'(m_rc));
         chk("resp_is_4M", 64'(bus.resp_is_4M_o), 64'(m_r4m));

         // advance the model to the state after the coming clock edge
         if (rst) begin
            flush_left = 0;
            rq.delete();
            prefer_d = 1'b0;
            m_rv = 0; m_rid = 0; m_rhit = 0; m_r4m = 0; m_rc = 0;
         end else begin
            m_rv = (win >= 0);
            if (win >= 0) begin
               e_lk     = tlb_lookup(e_va, e_as);
               m_rid    = (win == 1);
               m_rhit   = e_lk[33];
               m_r4m    = e_lk[32];
               m_rc     = e_lk[31:0];
               prefer_d = (win == 0);
            end
            if (flush_left > 0) flush_left--;
            else if (fl_take) begin
               flush_left = 2;
               m_fv = bus.flush_vaddr_i;
               m_fa = bus.flush_asid_i;
            end
            if (upd_go) void'(rq.pop_front());
            else if (bus.upd_valid_i && rq.size() == 0)
               rq.push_back('{vpn: bus.upd_vpn_i, asid: bus.upd_asid_i,
                              is4m: bus.upd_is_4M_i, c: bus.upd_content_i});
         end
      end
   end

   // ---------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.ilu_valid_i   = 0; bus.ilu_vaddr_i = 0; bus.ilu_asid_i = 0;
      bus.dlu_valid_i   = 0; bus.dlu_vaddr_i = 0; bus.dlu_asid_i = 0;
      bus.upd_valid_i   = 0; bus.upd_vpn_i = 0; bus.upd_asid_i = 0;
      bus.upd_is_4M_i   = 0; bus.upd_content_i = 0;
      bus.flush_valid_i = 0; bus.flush_vaddr_i = 0; bus.flush_asid_i = 0;
   endtask

   logic [62:0] want_upd;

   initial begin
      n_checks = 0; n_fail = 0; checking = 0;
      flush_left = 0; prefer_d = 0; m_fv = 0; m_fa = 0;
      m_rv = 0; m_rid = 0; m_rhit = 0; m_r4m = 0; m_rc = 0;
      rep = 0;
      for (int i = 0; i < 8; i++) begin e_v[i] = 0; e_key[i] = 0; e_c[i] = 0; e_4m[i] = 0; end
      rst = 1;
      idle_inputs();
      tick();
      checking = 1;
      tick(); tick();
      rst = 0;

      // reset state, then a plain instruction lookup on an empty TLB
      at_neg();
      chk("lit_reset_upd_ready", 64'(bus.upd_ready_o), 64'd1);
      chk("lit_reset_update", 64'(bus.tlb_update_o), 64'd0);
      chk("lit_reset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("lit_reset_flush_done", 64'(bus.flush_done_o), 64'd0);
      tick();
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h1234_5000; bus.ilu_asid_i = 9'd1;
      at_neg();
      chk("lit_lu_ready", 64'(bus.ilu_ready_o), 64'd1);
      chk("lit_lu_vaddr", 64'(bus.tlb_lu_vaddr_o), 64'h1234_5000);
      tick();
      bus.ilu_valid_i = 0;
      at_neg();
      chk("lit_resp1_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("lit_resp1_id", 64'(bus.resp_id_o), 64'd0);
      chk("lit_resp1_hit", 64'(bus.resp_hit_o), 64'd0);

      // refill then lookup of the same page sees the new entry
      tick();
      bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h12345; bus.upd_asid_i = 9'd1;
      bus.upd_is_4M_i = 0; bus.upd_content_i = 32'hDEAD_BEEF;
      tick();
      bus.upd_valid_i = 0;
      want_upd = {1'b1, 1'b0, 20'h12345, 9'd1, 32'hDEAD_BEEF};
      at_neg();
      chk("lit_update_word", 64'(bus.tlb_update_o), 64'(want_upd));
      tick();
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h1234_5000; bus.ilu_asid_i = 9'd1;
      tick();
      bus.ilu_valid_i = 0;
      at_neg();
      chk("lit_refill_hit", 64'(bus.resp_hit_o), 64'd1);
      chk("lit_refill_content", 64'(bus.resp_content_o), 64'hDEAD_BEEF);

      // data-only lookup hands the tie back to the instruction side, then I,D,I,D
      tick();
      bus.dlu_valid_i = 1; bus.dlu_vaddr_i = 32'h0000_7000; bus.dlu_asid_i = 9'd0;
      tick();
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h0000_3000; bus.ilu_asid_i = 9'd0;
      for (int k = 0; k < 4; k++) begin
         at_neg();
         chk("lit_rr_ilu", 64'(bus.ilu_ready_o), 64'((k % 2) == 0));
         chk("lit_rr_dlu", 64'(bus.dlu_ready_o), 64'((k % 2) == 1));
         if (k > 0) chk("lit_rr_resp_id", 64'(bus.resp_id_o), 64'(((k - 1) % 2) == 1));
         tick();
      end
      bus.ilu_valid_i = 0; bus.dlu_valid_i = 0;
      at_neg();
      chk("lit_rr_last_id", 64'(bus.resp_id_o), 64'd1);

      // flush + refill + lookup together
      tick();
      bus.flush_valid_i = 1; bus.flush_vaddr_i = 32'h0; bus.flush_asid_i = 9'd0;
      bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h00ABC; bus.upd_asid_i = 9'd2;
      bus.upd_is_4M_i = 0; bus.upd_content_i = 32'h1111_2222;
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h00AB_C000; bus.ilu_asid_i = 9'd2;
      at_neg();
      chk("lit_c0_flush_ready", 64'(bus.flush_ready_o), 64'd1);
      chk("lit_c0_upd_ready", 64'(bus.upd_ready_o), 64'd1);
      chk("lit_c0_ilu_ready", 64'(bus.ilu_ready_o), 64'd0);
      tick();
      bus.flush_valid_i = 0; bus.upd_valid_i = 0;
      at_neg();
      chk("lit_c1_tlb_flush", 64'(bus.tlb_flush_o), 64'd1);
      tick();
      at_neg();
      chk("lit_c2_flush_done", 64'(bus.flush_done_o), 64'd1);
      tick();
      want_upd = {1'b1, 1'b0, 20'h00ABC, 9'd2, 32'h1111_2222};
      at_neg();
      chk("lit_c3_update", 64'(bus.tlb_update_o), 64'(want_upd));
      chk("lit_c3_ilu_ready", 64'(bus.ilu_ready_o), 64'd0);
      tick();
      at_neg();
      chk("lit_c4_ilu_ready", 64'(bus.ilu_ready_o), 64'd1);
      tick();
      bus.ilu_valid_i = 0;
      at_neg();
      chk("lit_c5_hit", 64'(bus.resp_hit_o), 64'd1);
      chk("lit_c5_content", 64'(bus.resp_content_o), 64'h1111_2222);

      // refill, flush, then lookup misses
      tick();
      bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h12345; bus.upd_asid_i = 9'd1;
      bus.upd_content_i = 32'hDEAD_BEEF;
      tick();
      bus.upd_valid_i = 0;
      tick();
      bus.flush_valid_i = 1;
      tick();
      bus.flush_valid_i = 0;
      tick(); tick();
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h1234_5000; bus.ilu_asid_i = 9'd1;
      tick();
      bus.ilu_valid_i = 0;
      at_neg();
      chk("lit_flushed_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("lit_flushed_hit", 64'(bus.resp_hit_o), 64'd0);

      // reset during FLUSH drops the flush and the buffered refill
      tick();
      bus.flush_valid_i = 1;
      bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h55555; bus.upd_asid_i = 9'd3;
      bus.upd_content_i = 32'hCAFE_0001;
      tick();
      bus.flush_valid_i = 0; bus.upd_valid_i = 0;
      rst = 1;
      at_neg();
      chk("lit_rst_tlb_flush", 64'(bus.tlb_flush_o), 64'd0);
      tick();
      rst = 0;
      bus.ilu_valid_i = 1; bus.ilu_vaddr_i = 32'h5555_5000; bus.ilu_asid_i = 9'd3;
      at_neg();
      chk("lit_rst_no_done", 64'(bus.flush_done_o), 64'd0);
      chk("lit_rst_upd_ready", 64'(bus.upd_ready_o), 64'd1);
      chk("lit_rst_no_update", 64'(bus.tlb_update_o), 64'd0);
      chk("lit_rst_ilu_ready", 64'(bus.ilu_ready_o), 64'd1);
      tick();
      bus.ilu_valid_i = 0;
      at_neg();
      chk("lit_rst_refill_gone", 64'(bus.resp_hit_o), 64'd0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst = ($urandom_range(0, 255) == 0);
         bus.ilu_valid_i   = 1'($urandom_range(0, 1));
         bus.ilu_vaddr_i   = {17'd0, 3'($urandom_range(0, 7)), 12'($urandom)};
         bus.ilu_asid_i    = 9'($urandom_range(0, 1));
         bus.dlu_valid_i   = 1'($urandom_range(0, 1));
         bus.dlu_vaddr_i   = {17'd0, 3'($urandom_range(0, 7)), 12'($urandom)};
         bus.dlu_asid_i    = 9'($urandom_range(0, 1));
         bus.upd_valid_i   = ($urandom_range(0, 2) == 0);
         bus.upd_vpn_i     = {17'd0, 3'($urandom_range(0, 7))};
         bus.upd_asid_i    = 9'($urandom_range(0, 1));
         bus.upd_is_4M_i   = 1'($urandom_range(0, 1));
         bus.upd_content_i = $urandom;
         bus.flush_valid_i = ($urandom_range(0, 19) == 0);
         bus.flush_vaddr_i = $urandom;
         bus.flush_asid_i  = 9'($urandom);
      end
      tick();
      rst = 0;
      idle_inputs();
      tick(); tick(); tick();
      at_neg();
      checking = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_access_arbiter.md
Name: tlb_access_arbiter

Overview:
- Sequencer and arbiter in front of the shared cva6_tlb_sv32 instance.
- Shares the single TLB port between four sources: instruction-side lookups, data-side lookups, PTW refill updates, and SFENCE flushes.
- Orders these sources so that no lookup observes a half-flushed TLB.
- Registers each lookup result and returns it to the requester that issued it.

Parameters:
- ASID_WIDTH, 9, width of the ASID fields on all ports. The 9-bit update ASID field is built by zero-extending or truncating this width.
- VLEN, 32, virtual address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- ilu_valid_i  in  1  instruction lookup request
- ilu_ready_o  out  1  instruction lookup granted this cycle
- ilu_vaddr_i  in  VLEN  instruction lookup address
- ilu_asid_i  in  ASID_WIDTH  instruction lookup ASID
- dlu_valid_i / dlu_ready_o / dlu_vaddr_i / dlu_asid_i  same directions and widths as the ilu_* ports, for the data side
- upd_valid_i  in  1  PTW refill request
- upd_ready_o  out  1  refill buffer empty
- upd_vpn_i  in  20  refill VPN
- upd_asid_i  in  ASID_WIDTH  refill ASID
- upd_is_4M_i  in  1  refill is a superpage
- upd_content_i  in  32  refill PTE
- flush_valid_i  in  1  SFENCE request
- flush_ready_o  out  1  SFENCE accepted this cycle
- flush_vaddr_i  in  VLEN  SFENCE address
- flush_asid_i  in  ASID_WIDTH  SFENCE ASID
- flush_done_o  out  1  one-cycle pulse when the flush is complete
- tlb_flush_o  out  1  drives TLB flush_i
- tlb_vaddr_flush_o  out  VLEN  drives TLB vaddr_to_be_flushed_i
- tlb_asid_flush_o  out  ASID_WIDTH  drives TLB asid_to_be_flushed_i
- tlb_update_o  out  63  drives TLB update_i
- tlb_lu_access_o  out  1  drives TLB lu_access_i
- tlb_lu_vaddr_o  out  VLEN  drives TLB lu_vaddr_i
- tlb_lu_asid_o  out  ASID_WIDTH  drives TLB lu_asid_i
- tlb_lu_hit_i  in  1  from TLB, combinational in the lookup cycle
- tlb_lu_content_i  in  32  from TLB, combinational in the lookup cycle
- tlb_lu_is_4M_i  in  1  from TLB, combinational in the lookup cycle
- resp_valid_o  out  1  registered lookup response valid
- resp_id_o  out  1  response owner: 0 = instruction side, 1 = data side
- resp_hit_o  out  1  registered hit
- resp_content_o  out  32  registered PTE
- resp_is_4M_o  out  1  registered superpage flag

Behaviour:
- Reset, synchronous on rst_i=1:
  - state=IDLE, refill buffer empty, round-robin pointer=0 (instruction side preferred).
  - resp_* = 0, flush_done_o = 0.
  - All tlb_* outputs = 0.
  - Reset asserted mid-operation aborts any flush or refill in progress: nothing is issued, and no response or done pulse is produced for it.
- Whenever a tlb_* operation is not issued, its outputs are 0. update_i layout is {valid, is_4M, vpn[19:0], asid[8:0], content[31:0]}.
- Refill buffer (one entry):
  - upd_ready_o = buffer empty.
  - The buffer captures the request on upd_valid_i && upd_ready_o.
  - Acceptance is independent of FSM state.
- FSM states: IDLE, FLUSH, DRAIN.
- IDLE, priority flush > refill > lookups. In each cycle:
  - If flush_valid_i: flush_ready_o=1, latch vaddr and asid, go to FLUSH. No other TLB operation is issued.
  - Else if the buffer is full: drive tlb_update_o with valid=1 and the buffered fields for one cycle. The buffer is empty from the next cycle. Both lookup readys = 0.
  - Else grant one lookup:
    - If both sides request, grant the side the pointer selects. If one side requests, grant that side.
    - The winner's ready = 1. Drive tlb_lu_access_o=1 and the winner's vaddr and asid.
    - On grant, the pointer moves to the other side.
- FLUSH: tlb_flush_o=1 with the latched fields for exactly one cycle, then go to DRAIN.
- DRAIN: no TLB operation. flush_done_o=1 for this cycle, then go to IDLE.
- All readys are 0 in FLUSH and DRAIN.
- A buffered refill waits through FLUSH and DRAIN and is issued in the first IDLE cycle that has no flush request.
- Lookup response:
  - Registered, latency 1. The cycle after a lookup grant: resp_valid_o=1 with resp_id_o = the granted side, and the TLB hit, content and is_4M outputs captured at that clock edge.
  - In every other cycle resp_valid_o=0; resp_* fields hold their previous values.
  - There is no response backpressure.
- Ordering: a lookup granted in the cycle after a refill has been issued must see the new entry.
- Simultaneous events:
  - A refill accepted in the same cycle as a flush is retained in the buffer and issued after DRAIN.
  - A refill accepted in the same cycle the buffer drains is not possible, because ready is computed from the current buffer state.

Test Plan:
- Reset with both lookup sides idle → all outputs 0 and upd_ready_o=1. Then ilu_valid_i with vaddr 0x1234_5000 and asid 1 → ilu_ready_o=1 and tlb_lu_vaddr_o=0x1234_5000 in the same cycle. Next cycle: resp_valid_o=1, resp_id_o=0, resp_hit_o=0.
- Refill with vpn 0x12345, asid 1, content 0xDEAD_BEEF, then a lookup of vaddr 0x1234_5000 → tlb_update_o = {1,0,0x12345,1,0xDEADBEEF} one cycle after acceptance. The lookup response shows hit=1 and content=0xDEAD_BEEF.
- ilu and dlu both requesting continuously for 4 cycles → grants alternate I, D, I, D; responses arrive one cycle later with resp_id_o sequence 0, 1, 0, 1.
- flush_valid_i, upd_valid_i and ilu_valid_i asserted together in IDLE → cycle 0: flush accepted and refill buffered. Cycle 1: tlb_flush_o=1. Cycle 2: flush_done_o=1. Cycle 3: refill issued. Cycle 4: lookup granted.
- Flush, then a lookup of a previously refilled VPN → lookup response hit=0.
- rst_i asserted in the FLUSH cycle → no flush_done_o pulse, state returns to IDLE, the buffered refill is discarded, and upd_ready_o=1.
